hp_arbiter: RTL and testbench
=============================

HP_ARBITER -- requirements
Module: hp_arbiter

Interface
REQ-001 The block SHALL have parameter num_bits, default 16, giving operand/result width.
REQ-002 The block SHALL have parameter fpu_lat, default 1, giving cycles from operand launch to result sample; legal 1..15.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-006 The block SHALL have port req_ready  output  2  per-requester accept strobe.
REQ-007 The block SHALL have port req_a  input  2*num_bits  operand A; slice [i*num_bits +: num_bits] = requester i.
REQ-008 The block SHALL have port req_b  input  2*num_bits  operand B, sliced as req_a.
REQ-009 The block SHALL have port req_op  input  6  3-bit operation per requester, slice [i*3 +: 3]; bit0 = rounding mode (0 RN, 1 SR).
REQ-010 The block SHALL have port fpu_a  output  num_bits  operand A to the FPU datapath.
REQ-011 The block SHALL have port fpu_b  output  num_bits  operand B to the FPU datapath.
REQ-012 The block SHALL have port fpu_op  output  3  operation to the FPU datapath.
REQ-013 The block SHALL have port fpu_res  input  num_bits  FPU result.
REQ-014 The block SHALL have port fpu_flags  input  6  FPU flags {zero, inf, subN, Norm, QNan, SNan}, MSB first.
REQ-015 The block SHALL have port rsp_valid  output  1  response valid.
REQ-016 The block SHALL have port rsp_ready  input  1  response consumer ready.
REQ-017 The block SHALL have port rsp_id  output  1  index of the requester that owns the response.
REQ-018 The block SHALL have port rsp_data  output  num_bits  registered result.
REQ-019 The block SHALL have port rsp_flags  output  6  registered flags, same order as fpu_flags.

Function
REQ-020 The FSM SHALL have states IDLE, EXEC and RESP.
REQ-021 In IDLE, req_ready[g] SHALL be high combinationally iff req_valid[g] is high and g is the grant winner; at most one ready bit is high.
REQ-022 On a cycle with req_valid[g] & req_ready[g], the block SHALL latch req_a/b/op slice g and g into operand/id registers, load the counter with fpu_lat, and go to EXEC.
REQ-023 fpu_a, fpu_b and fpu_op SHALL be driven from the operand registers and held stable until the next accept.
REQ-024 In EXEC the counter SHALL decrement each cycle; on the EXEC cycle where count==1, fpu_res/fpu_flags SHALL be captured into rsp_data/rsp_flags and the FSM SHALL go to RESP, so EXEC lasts exactly fpu_lat cycles.
REQ-025 In RESP, rsp_valid SHALL be 1 with rsp_data/rsp_flags/rsp_id stable; when rsp_ready=1 the FSM SHALL go to IDLE; otherwise it holds.
REQ-026 req_ready SHALL be 00 in EXEC and RESP; the earliest next accept is the cycle after the RESP handshake; peak throughput is one op per fpu_lat+2 cycles.
REQ-027 A requester dropping req_valid before accept SHALL not be granted, with no state change.
REQ-028 req_op SHALL be forwarded unmodified; the block performs no arithmetic on operands.
REQ-029 fpu_lat outside 1..15 SHALL be rejected at elaboration.

Reset
REQ-030 While reset=0 at a clock edge, the block SHALL enter IDLE and clear operand registers, fpu_a/fpu_b/fpu_op, rsp_data/rsp_flags/rsp_id and the counter to 0, with rsp_valid=0 and req_ready=00.
REQ-031 Reset during EXEC or RESP SHALL discard the operation with no response; the round-robin pointer SHALL reset to 1 so requester 0 wins first.

Configuration
REQ-032 With HP_ARB_RR_EN defined, arbitration SHALL be round-robin: when both requesters are valid, the winner is the one not granted last; the pointer updates only on accept.
REQ-033 Without HP_ARB_RR_EN, requester 0 SHALL always win when valid, and the pointer register SHALL be absent.

Verification
REQ-034 Reset held low 3 cycles with req_valid=11 -> req_ready=00, rsp_valid=0, fpu_a/fpu_b/fpu_op=0.
REQ-035 fpu_lat=1, req0 ADD_RN (000), 0x3C00+0x4000, rsp_ready=1, accept at cycle T -> rsp_valid=1 at T+2 only, rsp_id=0, rsp_data=0x4200, rsp_flags=000100.
REQ-036 HP_ARB_RR_EN, both req_valid held 1, rsp_ready=1 -> rsp_id sequence 0,1,0,1; without macro -> 0,0,0,0.
REQ-037 rsp_ready=0 for 10 cycles in RESP -> rsp_valid/rsp_data stable, req_ready=00; rsp_ready=1 for one cycle -> next accept on the following cycle.
REQ-038 fpu_lat=4, req1 MUL_RN (100), 0x4000*0x4200 -> fpu_a/b stable over 4 EXEC cycles, rsp_valid at T+5, rsp_id=1, rsp_data=0x4600.
REQ-039 reset=0 for one cycle mid-EXEC -> no rsp_valid ever for that op; the next req0 request is served normally.

Source files
------------

// File: rtl/hp_arbiter_if.sv
// Bundle of requester, FPU-datapath and response signals for hp_arbiter.
// slave = arbiter side, master = environment side (requesters, FPU, consumer).
interface hp_arbiter_if #(
  parameter int num_bits = 16
);
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [2*num_bits-1:0] req_a;
  logic [2*num_bits-1:0] req_b;
  logic [5:0]            req_op;

  logic [num_bits-1:0]   fpu_a;
  logic [num_bits-1:0]   fpu_b;
  logic [2:0]            fpu_op;
  logic [num_bits-1:0]   fpu_res;
  logic [5:0]            fpu_flags;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [num_bits-1:0]   rsp_data;
  logic [5:0]            rsp_flags;

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    output req_ready,
    output fpu_a, fpu_b, fpu_op,
    input  fpu_res, fpu_flags,
    output rsp_valid, rsp_id, rsp_data, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_a, req_b, req_op,
    input  req_ready,
    input  fpu_a, fpu_b, fpu_op,
    output fpu_res, fpu_flags,
    input  rsp_valid, rsp_id, rsp_data, rsp_flags,
    output rsp_ready
  );
endinterface

// File: rtl/hp_arbiter.sv
// Two-requester arbiter in front of a fixed-latency FPU datapath (IDLE/EXEC/RESP).
// Define HP_ARB_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module hp_arbiter #(
  parameter int num_bits = 16,
  parameter int fpu_lat  = 1
) (
  input logic         clk,
  input logic         reset,
  hp_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [3:0] LAT_LOAD = 4'(fpu_lat);

  generate
    if (fpu_lat < 1 || fpu_lat > 15) begin : g_lat_check
      $error("hp_arbiter: fpu_lat must be in 1..15");
    end
  endgenerate

  logic [1:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [num_bits-1:0] opa_q, opa_d;
  logic [num_bits-1:0] opb_q, opb_d;
  logic [2:0]          op_q, op_d;
  logic                id_q, id_d;
  logic [num_bits-1:0] data_q, data_d;
  logic [5:0]          flags_q, flags_d;

  logic                win;
  logic [1:0]          ready;
  logic                accept;
  logic [num_bits-1:0] sel_a, sel_b;
  logic [2:0]          sel_op;

`ifdef HP_ARB_RR_EN
  // ptr_q holds the last granted requester; on contention the other one wins.
  logic ptr_q, ptr_d;

  always_comb begin
    if (bus.req_valid == 2'b11) begin
      win = ~ptr_q;
    end else begin
      win = ~bus.req_valid[0];
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = win;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    win = ~bus.req_valid[0];
  end
`endif

  // Ready is held low while reset is asserted so nothing is offered during reset.
  always_comb begin
    ready = 2'b00;
    if (state_q == IDLE && reset) begin
      ready = (2'b01 << win) & bus.req_valid;
    end
  end

  assign accept = |(bus.req_valid & ready);

  always_comb begin
    if (win) begin
      sel_a  = bus.req_a[2*num_bits-1:num_bits];
      sel_b  = bus.req_b[2*num_bits-1:num_bits];
      sel_op = bus.req_op[5:3];
    end else begin
      sel_a  = bus.req_a[num_bits-1:0];
      sel_b  = bus.req_b[num_bits-1:0];
      sel_op = bus.req_op[2:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    op_d    = op_q;
    id_d    = id_q;
    data_d  = data_q;
    flags_d = flags_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          opa_d   = sel_a;
          opb_d   = sel_b;
          op_d    = sel_op;
          id_d    = win;
          cnt_d   = LAT_LOAD;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // The FPU result is sampled on the last of fpu_lat EXEC cycles.
        if (cnt_q == 4'd1) begin
          data_d  = bus.fpu_res;
          flags_d = bus.fpu_flags;
          state_d = RESP;
        end
        cnt_d = cnt_q - 4'd1;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      op_q    <= op_d;
      id_q    <= id_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.fpu_a     = opa_q;
  assign bus.fpu_b     = opb_q;
  assign bus.fpu_op    = op_q;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_flags = flags_q;

endmodule

// File: tb/tb_hp_arbiter.sv
// Scoreboard bench for hp_arbiter: one instance with fpu_lat=1, one with fpu_lat=4,
// each fed by a stand-in FPU returning hand-tabulated results.
module tb_hp_arbiter;
  localparam int W = 16;
`ifdef HP_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  hp_arbiter_if #(.num_bits(W)) if1 ();
  hp_arbiter_if #(.num_bits(W)) if4 ();

  hp_arbiter #(.num_bits(W), .fpu_lat(1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  hp_arbiter #(.num_bits(W), .fpu_lat(4)) u4 (.clk(clk), .reset(reset), .bus(if4));

  logic [1:0]  rv[2];
  logic [31:0] ra[2];
  logic [31:0] rb[2];
  logic [5:0]  rop[2];
  logic        rr[2];

  logic [1:0]  rdy[2];
  logic [15:0] fa[2];
  logic [15:0] fb[2];
  logic [2:0]  fo[2];
  logic        sv[2];
  logic        sid[2];
  logic [15:0] sd[2];
  logic [5:0]  sf[2];

  // Stand-in FPU: two real half-precision vectors, otherwise a xor/op pattern.
  function automatic logic [21:0] fake_fpu(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] op);
    if (a == 16'h3C00 && b == 16'h4000 && op == 3'b000) return {6'b000100, 16'h4200};
    if (a == 16'h4000 && b == 16'h4200 && op == 3'b100) return {6'b000100, 16'h4600};
    return {3'b000, op, a ^ b};
  endfunction

  assign if1.req_valid = rv[0];
  assign if1.req_a     = ra[0];
  assign if1.req_b     = rb[0];
  assign if1.req_op    = rop[0];
  assign if1.rsp_ready = rr[0];
  assign {if1.fpu_flags, if1.fpu_res} = fake_fpu(if1.fpu_a, if1.fpu_b, if1.fpu_op);
  assign rdy[0] = if1.req_ready;
  assign fa[0]  = if1.fpu_a;
  assign fb[0]  = if1.fpu_b;
  assign fo[0]  = if1.fpu_op;
  assign sv[0]  = if1.rsp_valid;
  assign sid[0] = if1.rsp_id;
  assign sd[0]  = if1.rsp_data;
  assign sf[0]  = if1.rsp_flags;

  assign if4.req_valid = rv[1];
  assign if4.req_a     = ra[1];
  assign if4.req_b     = rb[1];
  assign if4.req_op    = rop[1];
  assign if4.rsp_ready = rr[1];
  assign {if4.fpu_flags, if4.fpu_res} = fake_fpu(if4.fpu_a, if4.fpu_b, if4.fpu_op);
  assign rdy[1] = if4.req_ready;
  assign fa[1]  = if4.fpu_a;
  assign fb[1]  = if4.fpu_b;
  assign fo[1]  = if4.fpu_op;
  assign sv[1]  = if4.rsp_valid;
  assign sid[1] = if4.rsp_id;
  assign sd[1]  = if4.rsp_data;
  assign sf[1]  = if4.rsp_flags;

  int errors = 0;
  int checks = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  typedef struct packed {
    logic        id;
    logic [15:0] d;
    logic [5:0]  f;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic push(input int k, input logic id, input logic [15:0] d, input logic [5:0] f);
    exp_t e;
    e.id = id;
    e.d  = d;
    e.f  = f;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  // Monitor state, written only by the monitor process.
  int          lat_of[2]  = '{1, 4};
  logic        have_op[2] = '{1'b0, 1'b0};
  logic        prv[2]     = '{1'b0, 1'b0};
  logic [15:0] efa[2];
  logic [15:0] efb[2];
  logic [2:0]  efo[2];
  logic [15:0] pd[2];
  logic [5:0]  pf[2];
  logic        pid[2];
  int          acc_cyc[2] = '{0, 0};
  int          acc_cnt[2] = '{0, 0};
  int          hs_cyc[2]  = '{0, 0};

  task automatic mon(input int k);
    exp_t e;
    if (!reset) begin
      have_op[k] = 1'b0;
      prv[k]     = 1'b0;
      return;
    end
    check(((rdy[k] & ~rv[k]) == 2'b00) && (rdy[k] != 2'b11) && !(sv[k] && rdy[k] != 2'b00),
          $sformatf("ready_legal_k%0d", k), {62'd0, rdy[k]}, {62'd0, rv[k]});
    if (have_op[k])
      check({fa[k], fb[k], fo[k]} === {efa[k], efb[k], efo[k]}, $sformatf("fpu_hold_k%0d", k),
            {29'd0, fa[k], fb[k], fo[k]}, {29'd0, efa[k], efb[k], efo[k]});
    if (sv[k] && !prv[k])
      check((cyc - acc_cyc[k]) == lat_of[k] + 1, $sformatf("rsp_latency_k%0d", k),
            64'(cyc - acc_cyc[k]), 64'(lat_of[k] + 1));
    if (sv[k] && prv[k])
      check({sid[k], sd[k], sf[k]} === {pid[k], pd[k], pf[k]}, $sformatf("rsp_stable_k%0d", k),
            {41'd0, sid[k], sd[k], sf[k]}, {41'd0, pid[k], pd[k], pf[k]});
    if (sv[k] && rr[k]) begin
      hs_cyc[k] = cyc;
      if (qsize(k) == 0) begin
        check(1'b0, $sformatf("unexpected_rsp_k%0d", k), {41'd0, sid[k], sd[k], sf[k]}, 64'd0);
      end else begin
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check({sid[k], sd[k], sf[k]} === {e.id, e.d, e.f}, $sformatf("rsp_k%0d", k),
              {41'd0, sid[k], sd[k], sf[k]}, {41'd0, e.id, e.d, e.f});
      end
    end
    for (int g = 0; g < 2; g++) begin
      if (rv[k][g] && rdy[k][g]) begin
        acc_cyc[k] = cyc;
        acc_cnt[k] = acc_cnt[k] + 1;
        have_op[k] = 1'b1;
        efa[k]     = ra[k][g*16 +: 16];
        efb[k]     = rb[k][g*16 +: 16];
        efo[k]     = rop[k][g*3 +: 3];
      end
    end
    prv[k] = sv[k];
    pd[k]  = sd[k];
    pf[k]  = sf[k];
    pid[k] = sid[k];
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) mon(k);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input int g, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op);
    ra[k][g*16 +: 16] = a;
    rb[k][g*16 +: 16] = b;
    rop[k][g*3 +: 3]  = op;
  endtask

  task automatic wait_acc(input int k, input int n);
    for (int i = 0; i < 100 && acc_cnt[k] < n; i++) tick();
    check(acc_cnt[k] >= n, $sformatf("accept_k%0d", k), 64'(acc_cnt[k]), 64'(n));
  endtask

  task automatic wait_drain(input int k);
    for (int i = 0; i < 100 && (qsize(k) != 0 || sv[k]); i++) tick();
    check(qsize(k) == 0 && !sv[k], $sformatf("drain_k%0d", k), 64'(qsize(k)), 64'd0);
  endtask

  task automatic issue(input int k, input int g, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] op, input bit do_push, input logic [15:0] ed,
                       input logic [5:0] ef);
    int n;
    set_req(k, g, a, b, op);
    if (do_push) push(k, 1'(g), ed, ef);
    n = acc_cnt[k] + 1;
    rv[k][g] = 1'b1;
    wait_acc(k, n);
    rv[k][g] = 1'b0;
  endtask

  initial begin
    int n;
    bit bad;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      rv[k]  = 2'b11;
      ra[k]  = '0;
      rb[k]  = '0;
      rop[k] = '0;
      rr[k]  = 1'b1;
    end
    repeat (3) tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check(rdy[k] == 2'b00, "rst_req_ready", {62'd0, rdy[k]}, 64'd0);
      check(sv[k] == 1'b0,   "rst_rsp_valid", {63'd0, sv[k]}, 64'd0);
      check(fa[k] == 16'h0,  "rst_fpu_a", {48'd0, fa[k]}, 64'd0);
      check(fb[k] == 16'h0,  "rst_fpu_b", {48'd0, fb[k]}, 64'd0);
      check(fo[k] == 3'b0,   "rst_fpu_op", {61'd0, fo[k]}, 64'd0);
      check(sd[k] == 16'h0,  "rst_rsp_data", {48'd0, sd[k]}, 64'd0);
      check(sf[k] == 6'h0,   "rst_rsp_flags", {58'd0, sf[k]}, 64'd0);
      check(sid[k] == 1'b0,  "rst_rsp_id", {63'd0, sid[k]}, 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    rv[0] = 2'b00;
    rv[1] = 2'b00;
    tick();

    issue(0, 0, 16'h3C00, 16'h4000, 3'b000, 1'b1, 16'h4200, 6'b000100);
    wait_drain(0);
    issue(1, 1, 16'h4000, 16'h4200, 3'b100, 1'b1, 16'h4600, 6'b000100);
    wait_drain(1);
    issue(0, 0, 16'hA5A5, 16'h0FF0, 3'b011, 1'b1, 16'hAA55, 6'b000011);
    wait_drain(0);
    issue(0, 1, 16'h8001, 16'h0001, 3'b111, 1'b1, 16'h8000, 6'b000111);
    wait_drain(0);

    // Both requesters held valid: alternate under round-robin, always 0 otherwise.
    set_req(0, 0, 16'h1234, 16'h00FF, 3'b001);
    set_req(0, 1, 16'h0F0F, 16'hF0F0, 3'b010);
    for (int i = 0; i < 4; i++) begin
      if (RR && (i % 2 == 1)) push(0, 1'b1, 16'hFFFF, 6'b000010);
      else                    push(0, 1'b0, 16'h12CB, 6'b000001);
    end
    n = acc_cnt[0] + 4;
    rv[0] = 2'b11;
    wait_acc(0, n);
    rv[0] = 2'b00;
    wait_drain(0);

    // Consumer stalls in RESP; a requester comes and goes without being granted.
    rr[0] = 1'b0;
    issue(0, 0, 16'hA5A5, 16'h0FF0, 3'b011, 1'b1, 16'hAA55, 6'b000011);
    for (int i = 0; i < 20 && !sv[0]; i++) tick();
    check(sv[0], "resp_reached", {63'd0, sv[0]}, 64'd1);
    set_req(0, 1, 16'h8001, 16'h0001, 3'b111);
    rv[0][1] = 1'b1;
    repeat (3) tick();
    rv[0][1] = 1'b0;
    set_req(0, 0, 16'h1234, 16'h00FF, 3'b001);
    push(0, 1'b0, 16'h12CB, 6'b000001);
    rv[0][0] = 1'b1;
    repeat (7) tick();
    n = acc_cnt[0] + 1;
    rr[0] = 1'b1;
    wait_acc(0, n);
    rv[0][0] = 1'b0;
    check(acc_cyc[0] == hs_cyc[0] + 1, "next_accept", 64'(acc_cyc[0]), 64'(hs_cyc[0] + 1));
    wait_drain(0);

    // Reset mid-EXEC on the fpu_lat=4 instance: that operation must vanish.
    issue(1, 0, 16'hA5A5, 16'h0FF0, 3'b011, 1'b0, 16'h0000, 6'b000000);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check(fa[1] == 16'h0 && fb[1] == 16'h0 && fo[1] == 3'b0, "rst_clr_fpu",
          {29'd0, fa[1], fb[1], fo[1]}, 64'd0);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sv[1]) bad = 1'b1;
    end
    check(!bad, "no_rsp_after_rst", {63'd0, bad}, 64'd0);
    tick();
    set_req(1, 0, 16'h1234, 16'h00FF, 3'b001);
    set_req(1, 1, 16'h0F0F, 16'hF0F0, 3'b010);
    push(1, 1'b0, 16'h12CB, 6'b000001);
    n = acc_cnt[1] + 1;
    rv[1] = 2'b11;
    wait_acc(1, n);
    rv[1] = 2'b00;
    wait_drain(1);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end
endmodule
